// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the six-stage pipeline: merges stage stall requests and MEM-stage
// exceptions into per-stage stalls, a flush strobe and redirect PC, plus watchdog and counters.
module pipeline_ctrl #(
   parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
   parameter int unsigned FLUSH_HOLD    = 0,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        exc_valid,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        busy_flush,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] exc_count
);

   localparam int unsigned WdogW = $clog2(STALL_TIMEOUT + 1);
   localparam logic [WdogW-1:0] WdogMax = WdogW'(STALL_TIMEOUT);
   localparam logic [3:0] HoldInit = 4'(FLUSH_HOLD);

   typedef enum logic [0:0] {StRun, StHold} state_e;

   state_e            state_q, state_d;
   logic [3:0]        hold_q, hold_d;
   logic [31:0]       target_q, target_d;
   logic [WdogW-1:0]  wdog_q, wdog_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       stall_cycles_q, stall_cycles_d;
   logic [15:0]       exc_count_q, exc_count_d;
   logic              exc_accept;
   logic [31:0]       exc_target;
   logic              stall_any;

   always_comb begin
      if (excepttype == 32'h1) begin
         exc_target = INT_VECTOR;
      end else if (excepttype == 32'he) begin
         exc_target = cp0_epc;
      end else begin
         exc_target = EXC_VECTOR;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      target_d   = target_q;
      stall      = 6'b000000;
      flush      = 1'b0;
      new_pc     = 32'h0;
      exc_accept = 1'b0;
      if (rst) begin
         unique case (state_q)
            StRun: begin
               if (exc_valid) begin
                  flush      = 1'b1;
                  new_pc     = exc_target;
                  exc_accept = 1'b1;
                  target_d   = exc_target;
                  if (FLUSH_HOLD > 0) begin
                     state_d = StHold;
                     hold_d  = HoldInit;
                  end
               end else if (stallreq_mem) begin
                  stall = 6'b011111;
               end else if (stallreq_ex) begin
                  stall = 6'b001111;
               end else if (stallreq_id) begin
                  stall = 6'b000111;
               end
            end
            StHold: begin
               // Target comes from the latched register so a changing EPC cannot move it.
               flush  = 1'b1;
               new_pc = target_q;
               if (hold_q <= 4'd1) begin
                  state_d = StRun;
                  hold_d  = 4'd0;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   assign stall_any = (stall != 6'b000000);

   always_comb begin
      wdog_d         = wdog_q;
      timeout_d      = timeout_q;
      stall_cycles_d = stall_cycles_q;
      exc_count_d    = exc_count_q;
      if (stall_any) begin
         if (wdog_q != WdogMax) begin
            wdog_d = wdog_q + 1'b1;
         end
         if (wdog_q >= WdogMax - 1'b1) begin
            timeout_d = 1'b1;
         end
         if (stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
         end
      end else begin
         wdog_d = '0;
      end
      if (exc_accept && (exc_count_q != 16'hFFFF)) begin
         exc_count_d = exc_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StRun;
         hold_q         <= 4'd0;
         target_q       <= 32'h0;
         wdog_q         <= '0;
         timeout_q      <= 1'b0;
         stall_cycles_q <= 32'h0;
         exc_count_q    <= 16'h0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         target_q       <= target_d;
         wdog_q         <= wdog_d;
         timeout_q      <= timeout_d;
         stall_cycles_q <= stall_cycles_d;
         exc_count_q    <= exc_count_d;
      end
   end

   assign busy_flush    = (state_q == StHold);
   assign stall_timeout = timeout_q;
   assign stall_cycles  = stall_cycles_q;
   assign exc_count     = exc_count_q;

endmodule
